// File: rtl/apb_pkg.sv
// Shared definitions for the APB register-file slave.
// Holds the FSM state encoding, register index constants, the default ID value,
// address/data field widths, the captured-request payload and decode helpers.
package apb_pkg;

    localparam int unsigned PSEL_W       = 3;
    localparam int unsigned PADDR_W      = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned ADDR_DEC_W   = 8;
    localparam int unsigned REG_IDX_W    = 3;
    localparam int unsigned WAIT_CNT_W   = 4;
    localparam int unsigned REG_RW_FIRST = 1;
    localparam int unsigned REG_RW_LAST  = 6;

    localparam logic [REG_IDX_W-1:0] REG_IDX_ID  = 3'd0;
    localparam logic [REG_IDX_W-1:0] REG_IDX_TXN = 3'd7;

    localparam logic [DATA_W-1:0] ID_VALUE_DEFAULT = 32'hA5B0_0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Transfer captured in the setup phase.
    typedef struct packed {
        logic [ADDR_DEC_W-1:0] addr;
        logic                  write;
        logic [DATA_W-1:0]     wdata;
    } apb_req_t;

    // Word index of a decoded byte address.
    function automatic logic [REG_IDX_W-1:0] reg_idx(input logic [ADDR_DEC_W-1:0] addr);
        return addr[4:2];
    endfunction

    // Misaligned, out-of-window, or write to a read-only register.
    function automatic logic decode_error(input apb_req_t req);
        logic [REG_IDX_W-1:0] idx;
        idx = reg_idx(req.addr);
        return (req.addr[1:0] != 2'b00) ||
               (req.addr[7:5] != 3'b000) ||
               (req.write && ((idx == REG_IDX_ID) || (idx == REG_IDX_TXN)));
    endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bridge-to-slave bus bundle.
// master: drives Pselx/Penable/Pwrite/Paddr/Pwdata, samples Prdata/Pready/Pslverr.
// slave : the reverse.
interface apb_slave_regfile_if;
    import apb_pkg::*;

    logic [PSEL_W-1:0]  Pselx;
    logic               Penable;
    logic               Pwrite;
    logic [PADDR_W-1:0] Paddr;
    logic [DATA_W-1:0]  Pwdata;
    logic [DATA_W-1:0]  Prdata;
    logic               Pready;
    logic               Pslverr;

    modport master (
        output Pselx, Penable, Pwrite, Paddr, Pwdata,
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        input  Pselx, Penable, Pwrite, Paddr, Pwdata,
        output Prdata, Pready, Pslverr
    );

endinterface

// File: rtl/apb_wait_counter.sv
// Access-phase wait-state down-counter.
// Ports: clk, rst (sync active-high), load/load_value (preset), dec (count down,
// saturating at zero), zero_c (count is zero).
module apb_wait_counter
    import apb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] load_value,
    input  logic                  dec,
    output logic                  zero_c
);

    logic [WAIT_CNT_W-1:0] count;

    // Load has priority over decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WAIT_CNT_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB slave with an 8-word register file.
// Word 0 = ID (read-only), words 1..6 = read/write, word 7 = transfer counter
// (read-only). Optional wait states ahead of Pready.
// Ports: Hclk (clock), Hreset (sync active-high reset), bus (APB slave modport).
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int unsigned       SLAVE_IDX   = 0,
    parameter int unsigned       WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
    input logic                Hclk,
    input logic                Hreset,
    apb_slave_regfile_if.slave bus
);

    localparam logic [1:0] SEL_BIT = 2'(SLAVE_IDX);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

    state_e                state;
    state_e                state_next;
    apb_req_t              req_q;
    apb_req_t              req_in;
    apb_req_t              resp_req;
    logic                  sel;
    logic                  setup;
    logic                  access;
    logic                  capture;
    logic                  enter_resp;
    logic                  commit;
    logic                  cnt_load;
    logic                  cnt_dec;
    logic                  cnt_zero;
    logic                  resp_err;
    logic [REG_IDX_W-1:0]  resp_idx;
    logic [DATA_W-1:0]     rd_data;
    logic                  wr_en;
    logic [REG_IDX_W-1:0]  commit_idx;
    logic [DATA_W-1:0]     prdata_q;
    logic                  pslverr_q;
    logic [DATA_W-1:0]     txn_count;
    logic [DATA_W-1:0]     rw_regs [REG_RW_FIRST:REG_RW_LAST];
    logic                  unused_bits;

    assign sel    = bus.Pselx[SEL_BIT];
    assign setup  = sel & ~bus.Penable;
    assign access = sel & bus.Penable;
    assign req_in = '{addr: bus.Paddr[ADDR_DEC_W-1:0], write: bus.Pwrite, wdata: bus.Pwdata};

    // Upper address bits and the other slaves' selects are intentionally ignored.
    assign unused_bits = ^{bus.Paddr[PADDR_W-1:ADDR_DEC_W], bus.Pselx};

    // With zero wait states RESP is entered straight from setup, before req_q holds it.
    assign resp_req = (state == ST_IDLE) ? req_in : req_q;
    assign resp_err = decode_error(resp_req);
    assign resp_idx = reg_idx(resp_req.addr);

    assign wr_en      = req_q.write && !decode_error(req_q);
    assign commit_idx = reg_idx(req_q.addr);

    apb_wait_counter u_wait_counter (
        .clk        (Hclk),
        .rst        (Hreset),
        .load       (cnt_load),
        .load_value (WAIT_LOAD),
        .dec        (cnt_dec),
        .zero_c     (cnt_zero)
    );

    // State register.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and control strobes.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        enter_resp = 1'b0;
        commit     = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (setup) begin
                    capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_next = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_load   = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!access) begin
                    state_next = ST_IDLE;
                end else if (cnt_zero) begin
                    state_next = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RESP: begin
                // A dropped select or enable here is an abort: nothing is committed.
                state_next = ST_IDLE;
                commit     = access;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Read mux for the response being entered.
    always_comb begin
        rd_data = '0;
        case (resp_idx)
            REG_IDX_ID:  rd_data = ID_VALUE;
            REG_IDX_TXN: rd_data = txn_count;
            default: begin
                for (int unsigned i = REG_RW_FIRST; i <= REG_RW_LAST; i++) begin
                    if (resp_idx == REG_IDX_W'(i)) begin
                        rd_data = rw_regs[i];
                    end
                end
            end
        endcase
    end

    // Captured request, response data and the register bank.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            req_q     <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            txn_count <= '0;
            for (int unsigned i = REG_RW_FIRST; i <= REG_RW_LAST; i++) begin
                rw_regs[i] <= '0;
            end
        end else begin
            if (capture) begin
                req_q <= req_in;
            end
            if (enter_resp) begin
                pslverr_q <= resp_err;
                prdata_q  <= (resp_err || resp_req.write) ? '0 : rd_data;
            end else if (state_next == ST_IDLE) begin
                pslverr_q <= 1'b0;
                prdata_q  <= '0;
            end
            if (commit) begin
                txn_count <= txn_count + DATA_W'(1);
                for (int unsigned i = REG_RW_FIRST; i <= REG_RW_LAST; i++) begin
                    if (wr_en && (commit_idx == REG_IDX_W'(i))) begin
                        rw_regs[i] <= req_q.wdata;
                    end
                end
            end
        end
    end

    assign bus.Pready  = (state == ST_RESP);
    assign bus.Prdata  = prdata_q;
    assign bus.Pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: dut0 (select bit 0, no wait states) and dut3 (select bit 1,
// three wait states) share one APB master.
module tb_apb_slave_regfile;

    logic        Hclk;
    logic        Hreset;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;

    int passed;
    int checks;

    logic [31:0] rd;
    logic        err;
    int          acc;

    apb_slave_regfile_if bus0 ();
    apb_slave_regfile_if bus3 ();

    assign bus0.Pselx   = psel;
    assign bus0.Penable = penable;
    assign bus0.Pwrite  = pwrite;
    assign bus0.Paddr   = paddr;
    assign bus0.Pwdata  = pwdata;
    assign bus3.Pselx   = psel;
    assign bus3.Penable = penable;
    assign bus3.Pwrite  = pwrite;
    assign bus3.Paddr   = paddr;
    assign bus3.Pwdata  = pwdata;

    apb_slave_regfile #(.SLAVE_IDX(0), .WAIT_STATES(0), .ID_VALUE(32'hA5B0_0001)) u_dut0 (
        .Hclk   (Hclk),
        .Hreset (Hreset),
        .bus    (bus0.slave)
    );

    apb_slave_regfile #(.SLAVE_IDX(1), .WAIT_STATES(3), .ID_VALUE(32'hA5B0_0001)) u_dut3 (
        .Hclk   (Hclk),
        .Hreset (Hreset),
        .bus    (bus3.slave)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic do_reset();
        Hreset  = 1'b1;
        psel    = 3'b000;
        penable = 1'b0;
        tick();
        tick();
        Hreset = 1'b0;
        tick();
    endtask

    // One APB transfer to dut d (0 -> dut0, 1 -> dut3); acc = access cycle with Pready, 0 on timeout.
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdat, output logic rerr, output int nacc);
        logic rdy;
        psel    = 3'(1 << d);
        penable = 1'b0;
        pwrite  = w;
        paddr   = a;
        pwdata  = wd;
        tick();
        penable = 1'b1;
        nacc    = 0;
        rdat    = 32'hDEAD_0BAD;
        rerr    = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            rdy = (d == 0) ? bus0.Pready : bus3.Pready;
            if (rdy) begin
                nacc = k;
                rdat = (d == 0) ? bus0.Prdata : bus3.Prdata;
                rerr = (d == 0) ? bus0.Pslverr : bus3.Pslverr;
                break;
            end
            tick();
        end
        tick();
        psel    = 3'b000;
        penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        passed  = 0;
        checks  = 0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;

        // Reset state
        do_reset();
        check("rst_pready0", 32'(bus0.Pready), 32'd0);
        check("rst_prdata0", bus0.Prdata, 32'd0);
        check("rst_pslverr0", 32'(bus0.Pslverr), 32'd0);
        check("rst_pready3", 32'(bus3.Pready), 32'd0);

        // Zero wait states: write then read word 1
        xfer(0, 1'b1, 32'h04, 32'hDEAD_BEEF, rd, err, acc);
        check("wr04_acc", 32'(acc), 32'd1);
        check("wr04_err", 32'(err), 32'd0);
        xfer(0, 1'b0, 32'h04, 32'h0, rd, err, acc);
        check("rd04_acc", 32'(acc), 32'd1);
        check("rd04_data", rd, 32'hDEAD_BEEF);
        check("rd04_err", 32'(err), 32'd0);
        check("idle_prdata", bus0.Prdata, 32'd0);
        check("idle_pready", 32'(bus0.Pready), 32'd0);

        xfer(0, 1'b1, 32'h18, 32'h1234_5678, rd, err, acc);
        xfer(0, 1'b0, 32'h18, 32'h0, rd, err, acc);
        check("rd18_data", rd, 32'h1234_5678);
        xfer(0, 1'b0, 32'h08, 32'h0, rd, err, acc);
        check("rd08_reset_val", rd, 32'd0);

        // Three wait states on dut3
        xfer(1, 1'b0, 32'h00, 32'h0, rd, err, acc);
        check("ws3_rd00_acc", 32'(acc), 32'd4);
        check("ws3_rd00_data", rd, 32'hA5B0_0001);
        check("ws3_rd00_err", 32'(err), 32'd0);
        xfer(1, 1'b1, 32'h10, 32'hCAFE_F00D, rd, err, acc);
        check("ws3_wr10_acc", 32'(acc), 32'd4);
        xfer(1, 1'b0, 32'h10, 32'h0, rd, err, acc);
        check("ws3_rd10_data", rd, 32'hCAFE_F00D);
        xfer(0, 1'b0, 32'h10, 32'h0, rd, err, acc);
        check("dut0_rd10_isolated", rd, 32'd0);

        // Decode errors
        xfer(0, 1'b1, 32'h00, 32'hFFFF_FFFF, rd, err, acc);
        check("err_wr00_err", 32'(err), 32'd1);
        check("err_wr00_data", rd, 32'd0);
        xfer(0, 1'b0, 32'h00, 32'h0, rd, err, acc);
        check("rd00_id_kept", rd, 32'hA5B0_0001);
        xfer(0, 1'b0, 32'h02, 32'h0, rd, err, acc);
        check("err_rd02_err", 32'(err), 32'd1);
        check("err_rd02_data", rd, 32'd0);
        xfer(0, 1'b0, 32'h20, 32'h0, rd, err, acc);
        check("err_rd20_err", 32'(err), 32'd1);
        check("err_rd20_data", rd, 32'd0);
        xfer(0, 1'b1, 32'h06, 32'h0000_1111, rd, err, acc);
        check("err_wr06_err", 32'(err), 32'd1);
        xfer(0, 1'b1, 32'h1C, 32'h0000_0099, rd, err, acc);
        check("err_wr1c_err", 32'(err), 32'd1);
        xfer(0, 1'b0, 32'h04, 32'h0, rd, err, acc);
        check("rd04_after_err", rd, 32'hDEAD_BEEF);

        // Back-to-back transfers and TXN_COUNT
        do_reset();
        xfer(0, 1'b1, 32'h08, 32'h1, rd, err, acc);
        xfer(0, 1'b1, 32'h0C, 32'h2, rd, err, acc);
        xfer(0, 1'b0, 32'h08, 32'h0, rd, err, acc);
        check("b2b_rd08", rd, 32'h1);
        xfer(0, 1'b0, 32'h1C, 32'h0, rd, err, acc);
        check("txn_first", rd, 32'd3);
        xfer(0, 1'b0, 32'h1C, 32'h0, rd, err, acc);
        check("txn_second", rd, 32'd4);

        // Abort in WAIT on dut3
        psel    = 3'b010;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h08;
        pwdata  = 32'h0000_0077;
        tick();
        penable = 1'b1;
        check("abort_acc1_pready", 32'(bus3.Pready), 32'd0);
        tick();
        check("abort_acc2_pready", 32'(bus3.Pready), 32'd0);
        psel = 3'b000;
        tick();
        check("abort_dropped_pready", 32'(bus3.Pready), 32'd0);
        penable = 1'b0;
        repeat (4) tick();
        check("abort_later_pready", 32'(bus3.Pready), 32'd0);
        xfer(1, 1'b0, 32'h08, 32'h0, rd, err, acc);
        check("abort_reg2", rd, 32'd0);
        xfer(1, 1'b0, 32'h1C, 32'h0, rd, err, acc);
        check("abort_txn", rd, 32'd1);

        // Reset during RESP of a write on dut0
        psel    = 3'b001;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h0C;
        pwdata  = 32'h0000_0055;
        tick();
        penable = 1'b1;
        check("rst_resp_pready", 32'(bus0.Pready), 32'd1);
        Hreset = 1'b1;
        tick();
        Hreset = 1'b0;
        check("rst_hold_pready", 32'(bus0.Pready), 32'd0);
        tick();
        check("rst_after_pready", 32'(bus0.Pready), 32'd0);
        psel    = 3'b000;
        penable = 1'b0;
        tick();
        xfer(0, 1'b0, 32'h0C, 32'h0, rd, err, acc);
        check("rst_reg3", rd, 32'd0);

        // Abort in RESP on dut0: select dropped in the access cycle
        psel    = 3'b001;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h10;
        pwdata  = 32'h0000_AAAA;
        tick();
        psel = 3'b000;
        tick();
        xfer(0, 1'b0, 32'h10, 32'h0, rd, err, acc);
        check("resp_abort_reg4", rd, 32'd0);
        xfer(0, 1'b0, 32'h1C, 32'h0, rd, err, acc);
        check("resp_abort_txn", rd, 32'd2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 Parameter SLAVE_IDX, default 0: the bit of Pselx that selects this slave (0..2).
REQ-002 Parameter WAIT_STATES, default 0: access-phase wait cycles before Pready (0..15).
REQ-003 Parameter ID_VALUE, default 32'hA5B0_0001: read-only value of register 0.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Hclk  input  1  clock; all state changes on its rising edge.
REQ-006 Hreset  input  1  synchronous active-high reset.
REQ-007 Pselx  input  3  slave selects from the APB bridge; only bit SLAVE_IDX is used.
REQ-008 Penable  input  1  APB access-phase indicator.
REQ-009 Pwrite  input  1  1 = write, 0 = read.
REQ-010 Paddr  input  32  byte address; only bits [7:0] are decoded.
REQ-011 Pwdata  input  32  write data.
REQ-012 Prdata  output  32  read data; registered.
REQ-013 Pready  output  1  transfer-complete strobe; decoded from the state register only.
REQ-014 Pslverr  output  1  error response; valid only while Pready=1; registered.

Function
REQ-015 States: IDLE, WAIT, RESP.
REQ-016 Setup detect: sel = Pselx[SLAVE_IDX]; setup = sel & ~Penable.
REQ-017 In IDLE on setup, the block SHALL capture Paddr[7:0], Pwrite and Pwdata.
- Next state is RESP if WAIT_STATES=0.
- Otherwise next state is WAIT, with the counter loaded to WAIT_STATES-1.
REQ-018 In WAIT with sel & Penable:
- counter=0 -> RESP.
- Otherwise decrement the counter and stay in WAIT.
REQ-019 Pready SHALL be 1 exactly during RESP.
- Zero wait states: Pready is high in the first access cycle.
- N wait states: Pready is high in access cycle N+1.
REQ-020 Register map: index = addr[4:2], 8 x 32-bit.
- 0 = ID (read-only).
- 1..6 = read/write.
- 7 = TXN_COUNT (read-only).
REQ-021 Decode error when any of:
- addr[1:0] != 0;
- addr[7:5] != 0;
- write to index 0 or 7.
REQ-022 On a decode error, in RESP the block SHALL drive Pslverr=1 and Prdata=0, and SHALL perform no write.
REQ-023 A valid write SHALL update the target register on the rising edge that ends RESP.
REQ-024 A valid read SHALL load Prdata on the edge entering RESP.
- Prdata is held through RESP.
- Prdata returns to 0 in IDLE.
REQ-025 TXN_COUNT SHALL increment by 1 at the end of every RESP, including error responses, and wrap from 32'hFFFF_FFFF to 0.
REQ-026 A read of TXN_COUNT SHALL return the value before the current transfer's increment.
REQ-027 RESP SHALL always go to IDLE.
- Back-to-back transfers are accepted when the next setup arrives in the cycle after RESP.
REQ-028 Abort: in WAIT or RESP, if sel=0 or Penable=0, the block SHALL return to IDLE with no write and no TXN_COUNT increment.
REQ-029 Setup with sel=0 in IDLE, or Penable=1 without a prior setup, SHALL be ignored.
REQ-030 With WAIT_STATES=0, the block SHALL be fully compatible with a master that does not sample Pready.

Reset
REQ-031 While Hreset=1 the block SHALL reset to:
- state IDLE, counter 0;
- Pready=0, Pslverr=0, Prdata=0;
- registers 1..6 = 0, TXN_COUNT = 0.
REQ-032 Reset mid-transfer SHALL discard the pending write and produce no Pready in the cycle after reset deasserts.

Structure
REQ-033 Shared package apb_pkg SHALL hold:
- the state encoding;
- register index constants (ID=0, TXN_COUNT=7);
- default ID_VALUE;
- address-field widths.
REQ-034 The FSM and the register bank SHALL stay in one module; sub-module apb_wait_counter (load, decrement, zero flag) is natural and permitted.

Verification
REQ-035 WAIT_STATES=0: write 32'hDEAD_BEEF to 0x04, then read 0x04 -> Pready high in each first access cycle, Prdata=32'hDEAD_BEEF, Pslverr=0.
REQ-036 WAIT_STATES=3: read 0x00 -> Pready low for 3 access cycles, high on the 4th, Prdata=32'hA5B0_0001.
REQ-037 Error cases each return Pslverr=1, Prdata=0 and leave registers unchanged:
- write to 0x00;
- read of 0x02;
- read of 0x20.
REQ-038 Three back-to-back transfers then read 0x1C -> Prdata=3; the next read of 0x1C returns 4.
REQ-039 Drop Pselx mid-WAIT on a write to 0x08 -> no Pready, register 2 stays 0, TXN_COUNT unchanged.
REQ-040 Assert Hreset during RESP of a write to 0x0C -> register 3=0 and Pready=0 after reset.
